// File: rtl/decode_hazard_scoreboard_if.sv
// -----------------------------------------------------------------------------
// decode_hazard_scoreboard_if
// Bundles the decode-side fields, write-back notifications and scoreboard
// outputs exchanged between the control unit and the hazard scoreboard.
//   master : control unit / pipeline side (drives decode + WB fields)
//   slave  : scoreboard side (drives stall/issue/busy/timeout)
// Signals:
//   id_valid, id_rs1[4:0], id_rs2[4:0], id_rd[4:0], id_use_rs1, id_use_rs2,
//   id_src_vec, id_wr_scalar, id_wr_vec, flush     decode stage fields
//   wb_wr_scalar, wb_wr_vec, wb_rd[4:0]             write-back notification
//   stall, issue, busy_scalar[31:0], busy_vec[31:0], timeout_err  status
// -----------------------------------------------------------------------------
interface decode_hazard_scoreboard_if;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic        id_src_vec;
  logic        id_wr_scalar;
  logic        id_wr_vec;
  logic        flush;
  logic        wb_wr_scalar;
  logic        wb_wr_vec;
  logic [4:0]  wb_rd;
  logic        stall;
  logic        issue;
  logic [31:0] busy_scalar;
  logic [31:0] busy_vec;
  logic        timeout_err;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_src_vec, id_wr_scalar, id_wr_vec, flush,
           wb_wr_scalar, wb_wr_vec, wb_rd,
    input  stall, issue, busy_scalar, busy_vec, timeout_err
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_src_vec, id_wr_scalar, id_wr_vec, flush,
           wb_wr_scalar, wb_wr_vec, wb_rd,
    output stall, issue, busy_scalar, busy_vec, timeout_err
  );
endinterface

// File: rtl/decode_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// decode_hazard_scoreboard
// Scoreboard / stall controller for the decode stage. Keeps a pending-write
// counter for each of the 32 scalar and 32 vector registers between decode
// issue and write-back, and stalls decode on RAW hazards or when the
// destination counter is saturated. No forwarding.
//
// Ports:
//   clk   in  clock, rising edge
//   rst   in  asynchronous reset, active-high
//   bus   slave modport of decode_hazard_scoreboard_if (decode fields, WB
//         fields, stall/issue/busy_scalar/busy_vec/timeout_err)
//
// Parameters:
//   CNT_W        width of each pending counter (max 2**CNT_W-1 writes in flight)
//   R0_ZERO      1: scalar r0 is hardwired, never busy, never a hazard
//   STALL_LIMIT  consecutive stall cycles that raise timeout_err
//
// Optional feature macro: STALL_TIMEOUT_EN
//   defined   : stall watchdog active, timeout_err sticky until rst
//   undefined : watchdog removed, timeout_err tied to 0
//
// FSM:
//   state    | meaning
//   ST_RUN   | decode flowing (or idle)
//   ST_STALL | decode held by a hazard; watchdog counting
// -----------------------------------------------------------------------------
module decode_hazard_scoreboard #(
  parameter int CNT_W       = 2,
  parameter int R0_ZERO     = 1,
  parameter int STALL_LIMIT = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  decode_hazard_scoreboard_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic             R0_HW   = (R0_ZERO != 0);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt_scalar [32];
  logic [CNT_W-1:0] cnt_vec    [32];

  logic [31:0] busy_s, busy_v;
  logic [31:0] inc_s, dec_s, inc_v, dec_v;
  logic        src1_busy, src2_busy;
  logic        raw, sat, hazard;
  logic        stall, issue;

  // Busy flags straight from the registered counters: a register is still
  // busy during the cycle its last write-back happens (no WB bypass).
  always_comb begin
    busy_s = '0;
    busy_v = '0;
    for (int i = 0; i < 32; i++) begin
      busy_s[i] = |cnt_scalar[i];
      busy_v[i] = |cnt_vec[i];
    end
  end

  // Source lookups; scalar r0 reads are never hazards when hardwired.
  always_comb begin
    src1_busy = 1'b0;
    src2_busy = 1'b0;
    if (bus.id_src_vec) begin
      src1_busy = busy_v[bus.id_rs1];
      src2_busy = busy_v[bus.id_rs2];
    end else begin
      src1_busy = busy_s[bus.id_rs1] & ~(R0_HW & (bus.id_rs1 == 5'd0));
      src2_busy = busy_s[bus.id_rs2] & ~(R0_HW & (bus.id_rs2 == 5'd0));
    end
  end

  // Destination saturation guards against counter wrap on back-to-back
  // writers (WAW). Lower pending counts are fine since WB completes in order.
  always_comb begin
    raw = (bus.id_use_rs1 & src1_busy) | (bus.id_use_rs2 & src2_busy);
    sat = (bus.id_wr_scalar & ~(R0_HW & (bus.id_rd == 5'd0)) &
           (cnt_scalar[bus.id_rd] == CNT_MAX)) |
          (bus.id_wr_vec & (cnt_vec[bus.id_rd] == CNT_MAX));
    hazard = raw | sat;
    stall  = bus.id_valid &  hazard & ~bus.flush;
    issue  = bus.id_valid & ~hazard & ~bus.flush;
  end

  // One-hot increment/decrement requests per register. Decrements at zero are
  // masked so a stray WB leaves the counter at 0.
  always_comb begin
    inc_s = '0;
    inc_v = '0;
    dec_s = '0;
    dec_v = '0;
    if (issue && bus.id_wr_scalar) inc_s = 32'd1 << bus.id_rd;
    if (issue && bus.id_wr_vec)    inc_v = 32'd1 << bus.id_rd;
    if (R0_HW) inc_s[0] = 1'b0;
    if (bus.wb_wr_scalar) dec_s = (32'd1 << bus.wb_rd) & busy_s;
    if (bus.wb_wr_vec)    dec_v = (32'd1 << bus.wb_rd) & busy_v;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        cnt_scalar[i] <= '0;
        cnt_vec[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        case ({inc_s[i], dec_s[i]})
          2'b10:   cnt_scalar[i] <= cnt_scalar[i] + CNT_ONE;
          2'b01:   cnt_scalar[i] <= cnt_scalar[i] - CNT_ONE;
          default: cnt_scalar[i] <= cnt_scalar[i];
        endcase
        case ({inc_v[i], dec_v[i]})
          2'b10:   cnt_vec[i] <= cnt_vec[i] + CNT_ONE;
          2'b01:   cnt_vec[i] <= cnt_vec[i] - CNT_ONE;
          default: cnt_vec[i] <= cnt_vec[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (stall) state_nxt = ST_STALL;
      end
      ST_STALL: begin
        if (!hazard || !bus.id_valid || bus.flush) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

`ifdef STALL_TIMEOUT_EN
  localparam int SC_W = $clog2(STALL_LIMIT + 1);
  localparam logic [SC_W-1:0] SC_LIMIT = SC_W'(STALL_LIMIT);

  logic [SC_W-1:0] stall_cnt, stall_cnt_nxt;
  logic            timeout_q;

  // Counts cycles spent in ST_STALL; cleared whenever the FSM heads to RUN.
  always_comb begin
    stall_cnt_nxt = stall_cnt;
    if (state_nxt == ST_RUN)
      stall_cnt_nxt = '0;
    else if (state == ST_STALL && stall_cnt != SC_LIMIT)
      stall_cnt_nxt = stall_cnt + SC_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt_nxt;
      if (stall_cnt_nxt == SC_LIMIT) timeout_q <= 1'b1;
    end
  end

  assign bus.timeout_err = timeout_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.stall       = stall;
  assign bus.issue       = issue;
  assign bus.busy_scalar = busy_s;
  assign bus.busy_vec    = busy_v;

endmodule

// File: tb/tb_decode_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_decode_hazard_scoreboard
// Directed bench for decode_hazard_scoreboard (CNT_W=2, R0_ZERO=1,
// STALL_LIMIT=64). Inputs change 1 ns after the rising edge; outputs are
// compared a further 1 ns later, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_decode_hazard_scoreboard;

`ifdef STALL_TIMEOUT_EN
  localparam logic EXP_TO = 1'b1;
`else
  localparam logic EXP_TO = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   passed;

  decode_hazard_scoreboard_if bus();

  decode_hazard_scoreboard #(
    .CNT_W       (2),
    .R0_ZERO     (1),
    .STALL_LIMIT (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic u1, input logic u2,
                          input logic sv, input logic ws, input logic wv);
    bus.id_valid     = v;
    bus.id_rs1       = rs1;
    bus.id_rs2       = rs2;
    bus.id_rd        = rd;
    bus.id_use_rs1   = u1;
    bus.id_use_rs2   = u2;
    bus.id_src_vec   = sv;
    bus.id_wr_scalar = ws;
    bus.id_wr_vec    = wv;
  endtask

  task automatic drive_wb(input logic ws, input logic wv, input logic [4:0] rd);
    bus.wb_wr_scalar = ws;
    bus.wb_wr_vec    = wv;
    bus.wb_rd        = rd;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    clk    = 1'b0;
    rst    = 1'b1;
    bus.flush = 1'b0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_wb(0, 0, 0);

    // Reset state
    #12;
    chk("rst_busy_scalar", bus.busy_scalar, 32'h0);
    chk("rst_busy_vec",    bus.busy_vec,    32'h0);
    chk("rst_stall",       bus.stall,       0);
    chk("rst_timeout",     bus.timeout_err, 0);
    rst = 1'b0;
    step();
    drive_id(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_issue", bus.issue, 1);

    // RAW on scalar r5, released the cycle after its WB
    step();
    drive_id(1, 0, 0, 5, 0, 0, 0, 1, 0);
    #1;
    chk("raw_wr_issue", bus.issue, 1);
    step();
    drive_id(1, 5, 0, 0, 1, 0, 0, 0, 0);
    #1;
    chk("raw_stall",       bus.stall,       1);
    chk("raw_no_issue",    bus.issue,       0);
    chk("raw_busy_scalar", bus.busy_scalar, 32'h0000_0020);
    step();
    chk("raw_stall_hold", bus.stall, 1);
    drive_wb(1, 0, 5);
    #1;
    chk("raw_no_bypass", bus.stall, 1);
    step();
    drive_wb(0, 0, 0);
    #1;
    chk("raw_release_issue", bus.issue,       1);
    chk("raw_release_busy",  bus.busy_scalar, 32'h0);

    // Same-cycle inc/dec on vector r3, plus scalar/vector independence
    step();
    drive_id(1, 0, 0, 3, 0, 0, 0, 0, 1);
    #1;
    chk("vec_wr_issue", bus.issue, 1);
    step();
    drive_wb(0, 1, 3);
    #1;
    chk("vec_same_cycle_issue", bus.issue, 1);
    step();
    drive_wb(0, 0, 0);
    drive_id(1, 3, 0, 0, 1, 0, 0, 0, 0);
    #1;
    chk("vec_same_cycle_busy", bus.busy_vec, 32'h0000_0008);
    chk("indep_scalar_read",   bus.issue,    1);
    bus.id_src_vec = 1'b1;
    #1;
    chk("indep_vec_read_stall", bus.stall, 1);
    step();
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_wb(0, 1, 3);
    step();
    drive_wb(0, 0, 0);
    #1;
    chk("vec_drain_busy", bus.busy_vec, 32'h0);

    // Saturation on scalar r7
    for (int k = 0; k < 3; k++) begin
      drive_id(1, 0, 0, 7, 0, 0, 0, 1, 0);
      #1;
      chk("sat_fill_issue", bus.issue, 1);
      step();
    end
    #1;
    chk("sat_stall",    bus.stall,       1);
    chk("sat_no_issue", bus.issue,       0);
    chk("sat_busy",     bus.busy_scalar, 32'h0000_0080);
    step();
    drive_wb(1, 0, 7);
    #1;
    chk("sat_stall_during_wb", bus.stall, 1);
    step();
    drive_wb(0, 0, 0);
    #1;
    chk("sat_release_issue", bus.issue, 1);
    step();
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_wb(1, 0, 7);
    step();
    step();
    step();
    drive_wb(0, 0, 0);
    #1;
    chk("sat_drain_busy", bus.busy_scalar, 32'h0);

    // Scalar r0 is hardwired
    drive_id(1, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) step();
    #1;
    chk("r0_issue_after_4", bus.issue,       1);
    chk("r0_never_busy",    bus.busy_scalar, 32'h0);
    drive_id(1, 0, 0, 0, 1, 1, 0, 0, 0);
    #1;
    chk("r0_read_issue", bus.issue, 1);

    // Flush during a hazard: no issue, no increment, WB still applies
    step();
    drive_id(1, 0, 0, 9, 0, 0, 0, 1, 0);
    step();
    drive_id(1, 9, 0, 10, 1, 0, 0, 1, 0);
    #1;
    chk("flush_pre_stall", bus.stall, 1);
    step();
    bus.flush = 1'b1;
    drive_wb(1, 0, 9);
    #1;
    chk("flush_stall", bus.stall, 0);
    chk("flush_issue", bus.issue, 0);
    step();
    bus.flush = 1'b0;
    drive_wb(0, 0, 0);
    #1;
    chk("flush_no_inc_wb_applied", bus.busy_scalar, 32'h0);
    chk("flush_then_issue",        bus.issue,       1);
    step();
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_wb(1, 0, 10);
    step();
    drive_wb(0, 0, 0);
    #1;
    chk("flush_cleanup_busy", bus.busy_scalar, 32'h0);

    // Asynchronous reset in the middle of a stall
    drive_id(1, 0, 0, 12, 0, 0, 0, 1, 0);
    step();
    drive_id(1, 12, 0, 0, 1, 0, 0, 0, 0);
    #1;
    chk("rst_mid_pre_stall", bus.stall, 1);
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_busy",  bus.busy_scalar, 32'h0);
    chk("rst_mid_stall", bus.stall,       0);
    #1;
    rst = 1'b0;
    step();

    // Long stall on scalar r20 (watchdog)
    drive_id(1, 0, 0, 20, 0, 0, 0, 1, 0);
    step();
    drive_id(1, 20, 0, 0, 1, 0, 0, 0, 0);
    repeat (10) step();
    chk("wd_early", bus.timeout_err, 0);
    repeat (60) step();
    chk("wd_stall_held", bus.stall,       1);
    chk("wd_timeout",    bus.timeout_err, EXP_TO);
    drive_wb(1, 0, 20);
    step();
    drive_wb(0, 0, 0);
    #1;
    chk("wd_release_issue",   bus.issue,       1);
    chk("wd_timeout_sticky",  bus.timeout_err, EXP_TO);
    step();
    rst = 1'b1;
    #1;
    chk("wd_cleared_by_rst", bus.timeout_err, 0);
    #1;
    rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
